// File: rtl/merge_readout_packer.sv
// ---------------------------------------------------------------------------
// merge_readout_packer
//
// Purpose:
//   Takes the key-sorted word stream from the merge stage and annotates each
//   word with first/last-of-key-group flags. One word is held back in a
//   lookahead register until the next word (or the end-of-event flush)
//   reveals whether it closes its group. Annotated words pass through a
//   one-entry push stage into a first-word-fall-through FIFO for the
//   readout consumer.
//
// Ports:
//   clk        - single clock, all logic on the rising edge
//   rst        - synchronous active-high reset
//   data_in    - sorted word from the merge stage
//   valid_in   - data_in valid (no upstream backpressure)
//   flush      - end-of-event pulse
//   data_out   - FIFO head word
//   first_out  - head word is the first of its key group
//   last_out   - head word is the last of its key group
//   valid_out  - FIFO non-empty
//   ready_in   - consumer accepts the head word
//   overflow   - sticky: a word was dropped because the FIFO was full
//   order_err  - sticky: key decreased within an event
//   group_cnt  - groups closed since reset/flush, saturating at 255
// ---------------------------------------------------------------------------
module merge_readout_packer #(
    parameter int DATA_WIDTH = 12,
    parameter int ACTIVE_MSB = 11,
    parameter int ACTIVE_LSB = 6,
    parameter int FIFO_AW    = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  first_out,
    output logic                  last_out,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic                  overflow,
    output logic                  order_err,
    output logic [7:0]            group_cnt
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int KW    = ACTIVE_MSB - ACTIVE_LSB + 1;
    localparam int EW    = DATA_WIDTH + 2;

    localparam logic [FIFO_AW:0]   FULL_CNT = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]   CNT_ONE  = {{FIFO_AW{1'b0}}, 1'b1};
    localparam logic [FIFO_AW-1:0] PTR_ONE  = {{(FIFO_AW - 1){1'b0}}, 1'b1};

    // Lookahead hold register
    logic                  r_hold_vld;
    logic [DATA_WIDTH-1:0] r_hold_data;
    logic                  r_hold_first;
    logic                  r_flush_pend;
    logic                  r_cnt_clr;

    // Push stage in front of the FIFO: entry is {first, last, data}
    logic                  r_push_vld;
    logic [EW-1:0]         r_push_entry;

    // FIFO storage and bookkeeping
    logic [EW-1:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0]    r_wr_ptr;
    logic [FIFO_AW-1:0]    r_rd_ptr;
    logic [FIFO_AW:0]      r_count;

    logic                  r_overflow;
    logic                  r_order_err;
    logic [7:0]            r_group_cnt;

    logic [KW-1:0]         w_key_in;
    logic [KW-1:0]         w_key_hold;
    logic                  w_key_diff;
    logic                  w_push;
    logic                  w_push_last;
    logic [EW-1:0]         w_push_entry;
    logic                  w_hold_load;
    logic                  w_hold_first_nxt;
    logic                  w_hold_clr;
    logic                  w_flush_pend_nxt;
    logic                  w_final_push;
    logic                  w_order_err;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_wr;
    logic [EW-1:0]         w_head;

    assign w_key_in     = data_in[ACTIVE_MSB:ACTIVE_LSB];
    assign w_key_hold   = r_hold_data[ACTIVE_MSB:ACTIVE_LSB];
    assign w_key_diff   = (w_key_in != w_key_hold);
    assign w_push_entry = {r_hold_first, w_push_last, r_hold_data};

    // Lookahead decision. A pending flush closes the held group first; any
    // word arriving in that same cycle starts a fresh event, so it is loaded
    // as a group start and is not compared against the word being closed.
    always_comb begin
        w_push           = 1'b0;
        w_push_last      = 1'b0;
        w_hold_load      = 1'b0;
        w_hold_first_nxt = 1'b1;
        w_hold_clr       = 1'b0;
        w_flush_pend_nxt = 1'b0;
        w_final_push     = 1'b0;
        w_order_err      = 1'b0;
        if (r_flush_pend) begin
            w_push       = 1'b1;
            w_push_last  = 1'b1;
            w_final_push = 1'b1;
            w_hold_clr   = 1'b1;
            if (valid_in) begin
                w_hold_load      = 1'b1;
                w_flush_pend_nxt = flush;
            end
        end else if (valid_in) begin
            w_hold_load      = 1'b1;
            w_flush_pend_nxt = flush;
            if (r_hold_vld) begin
                w_push           = 1'b1;
                w_push_last      = w_key_diff;
                w_hold_first_nxt = w_key_diff;
                w_order_err      = (w_key_in < w_key_hold);
            end
        end else if (flush && r_hold_vld) begin
            w_push       = 1'b1;
            w_push_last  = 1'b1;
            w_final_push = 1'b1;
            w_hold_clr   = 1'b1;
        end
    end

    assign w_full = (r_count == FULL_CNT);
    assign w_pop  = valid_out && ready_in;
    // A push into a full FIFO is still accepted when the head leaves in the
    // same cycle.
    assign w_wr   = r_push_vld && (!w_full || w_pop);

    // Control state, sticky flags and group counter. The counter is cleared
    // one cycle after a flush-driven final push so the closing count is
    // visible for a cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_vld   <= 1'b0;
            r_flush_pend <= 1'b0;
            r_cnt_clr    <= 1'b0;
            r_push_vld   <= 1'b0;
            r_overflow   <= 1'b0;
            r_order_err  <= 1'b0;
            r_group_cnt  <= 8'd0;
        end else begin
            if (w_hold_load) begin
                r_hold_vld <= 1'b1;
            end else if (w_hold_clr) begin
                r_hold_vld <= 1'b0;
            end
            r_flush_pend <= w_flush_pend_nxt;
            r_cnt_clr    <= w_final_push;
            r_push_vld   <= w_push;
            if (w_order_err) begin
                r_order_err <= 1'b1;
            end
            if (r_push_vld && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
            if (r_cnt_clr) begin
                r_group_cnt <= (w_push && w_push_last) ? 8'd1 : 8'd0;
            end else if (w_push && w_push_last && (r_group_cnt != 8'hFF)) begin
                r_group_cnt <= r_group_cnt + 8'd1;
            end
        end
    end

    // Datapath registers; only meaningful while their valid bits are set.
    always_ff @(posedge clk) begin
        if (w_hold_load) begin
            r_hold_data  <= data_in;
            r_hold_first <= w_hold_first_nxt;
        end
        if (w_push) begin
            r_push_entry <= w_push_entry;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_wr && !w_pop) begin
                r_count <= r_count + CNT_ONE;
            end else if (!w_wr && w_pop) begin
                r_count <= r_count - CNT_ONE;
            end
        end
    end

    // FIFO storage.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= r_push_entry;
        end
    end

    assign w_head    = r_mem[r_rd_ptr];
    assign data_out  = w_head[DATA_WIDTH-1:0];
    assign last_out  = w_head[DATA_WIDTH];
    assign first_out = w_head[DATA_WIDTH+1];
    assign valid_out = (r_count != '0);
    assign overflow  = r_overflow;
    assign order_err = r_order_err;
    assign group_cnt = r_group_cnt;

endmodule

// File: doc/merge_readout_packer.md
MERGE_READOUT_PACKER -- requirements
Module: merge_readout_packer

Interface
REQ-001 Parameters SHALL be:
- DATA_WIDTH, default 12, stream word width.
- ACTIVE_MSB, default 11, key field MSB.
- ACTIVE_LSB, default 6, key field LSB.
- FIFO_AW, default 5, FIFO address bits (depth 2**FIFO_AW).
REQ-002 Ports SHALL be:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- data_in  in  DATA_WIDTH  sorted word from merge stage.
- valid_in  in  1  data_in valid; no backpressure upstream.
- flush  in  1  end-of-event pulse.
- data_out  out  DATA_WIDTH  FIFO head word.
- first_out  out  1  head word is first of its key group.
- last_out  out  1  head word is last of its key group.
- valid_out  out  1  FIFO non-empty.
- ready_in  in  1  consumer accepts head word.
- overflow  out  1  sticky: word dropped, FIFO full.
- order_err  out  1  sticky: key decreased within event.
- group_cnt  out  8  groups closed since reset/flush; saturates at 255.

Function
REQ-003 The key SHALL be data_in[ACTIVE_MSB:ACTIVE_LSB]; unsigned compare.
REQ-004 Lookahead: the block SHALL hold one word (hold_vld, hold_data, hold_first) until its last flag is known.
REQ-005 On valid_in with hold_vld=0, the block SHALL load hold with hold_first=1 and push nothing.
REQ-006 On valid_in with hold_vld=1:
- The block SHALL push hold with last = (key(data_in) != key(hold)).
- It SHALL load data_in into hold with hold_first = that last value.
REQ-007 On flush with valid_in=0 and hold_vld=1, the block SHALL push hold with last=1 and clear hold_vld.
REQ-008 Flush with hold_vld=0 and valid_in=0 SHALL push nothing.
REQ-009 Flush together with valid_in:
- The block SHALL apply REQ-005/006 and set flush_pend.
- On the next cycle it SHALL push hold with last=1 and clear hold_vld.
- valid_in is not asserted in that next cycle (upstream idle after event end); if it is, the word is treated as a new event after the pending push.
REQ-010 Each push with last=1 SHALL increment group_cnt, saturating at 255; group_cnt SHALL clear on the cycle after a flush-driven final push completes.
REQ-011 order_err SHALL set when valid_in, hold_vld=1 and key(data_in) < key(hold); the word is still processed normally.
REQ-012 FIFO depth SHALL be 2**FIFO_AW entries; each entry stores {first, last, data}.
REQ-013 A word pushed at edge N SHALL be visible on data_out/valid_out after edge N+1 when the FIFO was empty (1-cycle latency, first-word-fall-through).
REQ-014 Pop SHALL occur when valid_out && ready_in; data_out SHALL advance the following cycle.
REQ-015 Push and pop in the same cycle SHALL be legal in every state, including full; occupancy is unchanged.
REQ-016 Push when full with no pop SHALL drop the word, set overflow, and leave FIFO contents unchanged.
REQ-017 Pointers SHALL wrap modulo depth; full/empty SHALL use an occupancy counter of FIFO_AW+1 bits.
REQ-018 With valid_out=0, data_out/first_out/last_out SHALL be don't-care; the bench shall not check them.

Reset
REQ-019 rst SHALL clear FIFO occupancy and pointers, hold_vld, flush_pend, overflow, order_err and group_cnt; valid_out=0 on the cycle after rst is sampled.
REQ-020 rst asserted mid-event SHALL discard held and queued words; no partial group SHALL be emitted afterwards.
REQ-021 FIFO storage SHALL need no reset.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Keys 3,3,5 then flush, ready_in=1 -> outputs (f1,l0),(f0,l1),(f1,l1); group_cnt reaches 2; valid_out first high 2 cycles after the second valid_in.
- Single word key 7, flush in same cycle as valid_in -> one entry first=1,last=1, pushed one cycle later.
- ready_in=0, 2**FIFO_AW+2 words of distinct keys plus flush -> exactly 32 entries retained, overflow=1, order of retained entries preserved.
- FIFO full, push and pop in same cycle -> occupancy stays 32, overflow stays 0.
- Keys 9 then 4 -> order_err=1; both words still output.
- rst mid-stream with 3 words queued -> valid_out=0 next cycle; later event output shows no residue.
